wb_stepgen: RTL and testbench

WB_STEPGEN -- requirements
Module: wb_stepgen

---
 rtl/stepgen_pkg.sv | 34 +++
 rtl/stepgen_channel.sv | 92 +++++++++
 rtl/wb_stepgen.sv | 152 +++++++++++++++
 tb/tb_wb_stepgen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepgen_pkg.sv
// Shared constants for the Wishbone step/dir generator: register offsets,
// CTRL/STATUS bit positions, channel FSM states and a byte-lane merge helper.
package stepgen_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_STEPS  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_IE    = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } ch_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/stepgen_channel.sv
// One step/dir channel: IDLE/HIGH/LOW FSM, phase timer and remaining-step counter.
// state_o is the FSM state; step and busy are decoded from it by the parent.
module stepgen_channel
  import stepgen_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             halt_i,
  input  logic             dir_cfg_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] steps_i,
  output ch_state_e        state_o,
  output logic             dir_o,
  output logic             done_o,
  output logic             done_evt_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             dir_d;
  logic [CNT_W-1:0] phase_load;

  // Timer counts down to zero, so a phase lasts phase_load+1 = max(PERIOD,1) cycles.
  // PERIOD is sampled only when a phase is loaded, so mid-phase writes wait.
  assign phase_load = (period_i == '0) ? '0 : period_i - CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    remain_d   = remain_q;
    dir_d      = dir_o;
    done_evt_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i && !halt_i) begin
          if (steps_i == '0) begin
            done_evt_o = 1'b1;
          end else begin
            state_d  = ST_HIGH;
            timer_d  = phase_load;
            remain_d = steps_i;
            dir_d    = dir_cfg_i;
          end
        end
      end
      ST_HIGH, ST_LOW: begin
        if (abort_i || halt_i) begin
          state_d    = ST_IDLE;
          done_evt_o = 1'b1;
        end else if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (state_q == ST_HIGH) begin
          state_d = ST_LOW;
          timer_d = phase_load;
        end else if (remain_q == CNT_W'(1)) begin
          state_d    = ST_IDLE;
          remain_d   = '0;
          done_evt_o = 1'b1;
        end else begin
          state_d  = ST_HIGH;
          timer_d  = phase_load;
          remain_d = remain_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      remain_q <= '0;
      dir_o    <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      remain_q <= remain_d;
      dir_o    <= dir_d;
      done_o   <= done_evt_o;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/wb_stepgen.sv
// Wishbone classic slave with NCH step/dir generator channels.
// Handshake: a request (cyc & stb while ack low) is acked for exactly one cycle on the next cycle; writes commit at the end of that ack cycle.
module wb_stepgen
  import stepgen_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic           halt_i,
  output logic [NCH-1:0] step_o,
  output logic [NCH-1:0] dir_o,
  output logic [NCH-1:0] busy_o,
  output logic [NCH-1:0] done_o,
  output logic           irq_o
);

  logic        req, wr;
  logic        ack_q, we_q;
  logic [3:0]  sel_q, ch_q;
  logic [1:0]  reg_q;
  logic [31:0] dat_q, rdata;
  logic        unused_adr;

  logic [NCH-1:0] hit, start, abort, clr_done, done_evt;
  logic [NCH-1:0] dir_q, ie_q, done_q;
  logic [CNT_W-1:0] period_q [NCH];
  logic [CNT_W-1:0] steps_q  [NCH];
  ch_state_e        ch_state [NCH];

  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr  = ack_q & we_q;

  // The request is captured so the ack-cycle commit does not depend on the master still holding the bus.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= '0;
      ch_q  <= '0;
      reg_q <= '0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) begin
        we_q  <= wbs_we_i;
        sel_q <= wbs_sel_i;
        ch_q  <= wbs_adr_i[7:4];
        reg_q <= wbs_adr_i[3:2];
        dat_q <= wbs_dat_i;
      end
    end
  end

  always_comb begin
    hit      = '0;
    start    = '0;
    abort    = '0;
    clr_done = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i]      = (ch_q == 4'(i));
      start[i]    = wr & hit[i] & (reg_q == REG_CTRL) & sel_q[0] & dat_q[CTRL_START];
      abort[i]    = wr & hit[i] & (reg_q == REG_CTRL) & sel_q[0] & dat_q[CTRL_ABORT];
      clr_done[i] = wr & hit[i] & (reg_q == REG_STATUS) & sel_q[0] & dat_q[STAT_DONE];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      dir_q  <= '0;
      ie_q   <= '0;
      done_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= CNT_W'(1);
        steps_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr && hit[i]) begin
          case (reg_q)
            REG_CTRL: begin
              if (sel_q[0]) begin
                dir_q[i] <= dat_q[CTRL_DIR];
                ie_q[i]  <= dat_q[CTRL_IE];
              end
            end
            REG_PERIOD: period_q[i] <= CNT_W'(merge_bytes(32'(period_q[i]), dat_q, sel_q));
            REG_STEPS:  steps_q[i]  <= CNT_W'(merge_bytes(32'(steps_q[i]), dat_q, sel_q));
            default: ;
          endcase
        end
        // A completion in the same cycle as a W1C keeps the flag set.
        done_q[i] <= done_evt[i] | (done_q[i] & ~clr_done[i]);
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (hit[i]) begin
        case (reg_q)
          REG_CTRL: begin
            rdata[CTRL_DIR] = dir_q[i];
            rdata[CTRL_IE]  = ie_q[i];
          end
          REG_PERIOD: rdata = 32'(period_q[i]);
          REG_STEPS:  rdata = 32'(steps_q[i]);
          default: begin
            rdata[STAT_BUSY] = busy_o[i];
            rdata[STAT_DONE] = done_q[i];
          end
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = ack_q ? rdata : '0;
  assign irq_o     = |(done_q & ie_q);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    stepgen_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (wb_clk_i),
      .rst_n      (wb_rst_ni),
      .start_i    (start[g]),
      .abort_i    (abort[g]),
      .halt_i     (halt_i),
      .dir_cfg_i  (dat_q[CTRL_DIR]),
      .period_i   (period_q[g]),
      .steps_i    (steps_q[g]),
      .state_o    (ch_state[g]),
      .dir_o      (dir_o[g]),
      .done_o     (done_o[g]),
      .done_evt_o (done_evt[g])
    );
    assign step_o[g] = (ch_state[g] == ST_HIGH);
    assign busy_o[g] = (ch_state[g] != ST_IDLE);
  end

endmodule

// File: tb/tb_wb_stepgen.sv
// Directed bench for wb_stepgen (NCH=4): register read-back table plus
// hand-written move, halt, abort, irq and reset sequences.
module tb_wb_stepgen;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]     sel = '0;
  logic [31:0]    adr = '0, wdat = '0;
  logic           ack;
  logic [31:0]    rdat;
  logic           halt = 1'b0;
  logic [NCH-1:0] step, dir, busy, done;
  logic           irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stepgen #(.NCH(NCH), .CNT_W(32)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .halt_i    (halt),
    .step_o    (step),
    .dir_o     (dir),
    .busy_o    (busy),
    .done_o    (done),
    .irq_o     (irq)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives at a falling edge, returns at the falling edge inside the ack cycle.
  task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, output logic [31:0] rd);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    if (!ack) check("ack_timeout", 32'(ack), 32'd1);
    rd = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(a, d, 4'hF, 1'b1, rd);
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(a, 32'h0, 4'hF, 1'b0, rd);
    check(name, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic got_step [30];
    logic got_done [30];
    logic exp_step [30];
    int   w [6];
    int   pos;
    bit   found;

    vecs[0]  = '{32'h04,  32'h12345678, 4'hF, 32'h12345678};
    vecs[1]  = '{32'h04,  32'hAABBCCDD, 4'h1, 32'h123456DD};
    vecs[2]  = '{32'h04,  32'hAABBCCDD, 4'h6, 32'h12BBCCDD};
    vecs[3]  = '{32'h18,  32'h00000007, 4'hF, 32'h00000007};
    vecs[4]  = '{32'h18,  32'hFFFFFF00, 4'h8, 32'hFF000007};
    vecs[5]  = '{32'h64,  32'h00000005, 4'hF, 32'h00000000};
    vecs[6]  = '{32'h60,  32'h0000000F, 4'hF, 32'h00000000};
    vecs[7]  = '{32'h00,  32'h0000000E, 4'hF, 32'h0000000A};
    vecs[8]  = '{32'h00,  32'h00000000, 4'h0, 32'h0000000A};
    vecs[9]  = '{32'h00,  32'hFFFFFF00, 4'hE, 32'h0000000A};
    vecs[10] = '{32'h00,  32'h00000000, 4'h1, 32'h00000000};
    vecs[11] = '{32'h3C,  32'hFFFFFFFF, 4'hF, 32'h00000000};
    vecs[12] = '{32'h108, 32'h00000003, 4'hF, 32'h00000003};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_dat", rdat, 0);
    check("rst_step", 32'(step), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_irq", 32'(irq), 0);
    rst_n = 1'b1;
    rd_check("rst_period", 32'h04, 32'h1);
    rd_check("rst_steps", 32'h08, 32'h0);
    rd_check("rst_status", 32'h0C, 32'h0);

    // Register table
    for (int i = 0; i < 13; i++) begin
      wb_xfer(vecs[i].adr, vecs[i].wdat, vecs[i].sel, 1'b1, rd);
      wb_xfer(vecs[i].adr, 32'h0, 4'hF, 1'b0, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    @(negedge clk);
    check("dat_idle", rdat, 0);

    // PERIOD=3 STEPS=4 DIR=1: 4 pulses of 3 high / 3 low
    wr(32'h04, 32'd3);
    wr(32'h08, 32'd4);
    wr(32'h00, 32'h3);
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      check($sformatf("m40_step_k%0d", k), 32'(step[0]), 32'((k < 24) && ((k / 3) % 2 == 0)));
      check($sformatf("m40_busy_k%0d", k), 32'(busy[0]), 32'(k < 24));
      check($sformatf("m40_done_k%0d", k), 32'(done[0]), 32'(k == 24));
      check($sformatf("m40_dir_k%0d", k), 32'(dir[0]), 32'd1);
    end

    // STEPS=0 START on ch1
    wr(32'h18, 32'd0);
    wr(32'h10, 32'h1);
    check("z_done_ack", 32'(done[1]), 0);
    @(negedge clk);
    check("z_done", 32'(done[1]), 1);
    check("z_busy", 32'(busy[1]), 0);
    check("z_step", 32'(step[1]), 0);
    @(negedge clk);
    check("z_done_end", 32'(done[1]), 0);
    rd_check("z_status", 32'h1C, 32'h2);
    wr(32'h1C, 32'h2);
    rd_check("z_status_clr", 32'h1C, 32'h0);

    // Busy visible right after START, then ABORT, then START+ABORT together
    wr(32'h14, 32'd3);
    wr(32'h18, 32'd2);
    wr(32'h10, 32'h1);
    rd_check("b_status_busy", 32'h1C, 32'h1);
    wr(32'h10, 32'h4);
    @(negedge clk);
    check("ab_busy", 32'(busy[1]), 0);
    check("ab_done", 32'(done[1]), 1);
    check("ab_step", 32'(step[1]), 0);
    wr(32'h10, 32'h5);
    @(negedge clk);
    check("sa_busy", 32'(busy[1]), 0);
    @(negedge clk);
    check("sa_busy2", 32'(busy[1]), 0);
    wr(32'h1C, 32'h2);

    // halt during 2nd pulse of a 10-step move
    wr(32'h04, 32'd2);
    wr(32'h08, 32'd10);
    wr(32'h00, 32'h1);
    for (int k = 0; k < 5; k++) @(negedge clk);
    check("h_step_before", 32'(step[0]), 1);
    halt = 1'b1;
    @(negedge clk);
    check("h_step", 32'(step[0]), 0);
    check("h_busy", 32'(busy[0]), 0);
    check("h_done", 32'(done[0]), 1);
    wr(32'h00, 32'h1);
    @(negedge clk);
    check("h_start_ign", 32'(busy[0]), 0);
    check("h_start_nodone", 32'(done[0]), 0);
    halt = 1'b0;
    @(negedge clk);
    check("h_after", 32'(busy[0]), 0);

    // PERIOD=0 -> 1/1 pulses
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd3);
    wr(32'h00, 32'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("p0_step_k%0d", k), 32'(step[0]), 32'((k < 6) && (k % 2 == 0)));
      check($sformatf("p0_done_k%0d", k), 32'(done[0]), 32'(k == 6));
    end

    // PERIOD 2 -> 5 written during the first LOW phase
    wr(32'h04, 32'd2);
    wr(32'h08, 32'd3);
    wr(32'h00, 32'h1);
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          got_step[k] = step[0];
          got_done[k] = done[0];
        end
      end
      begin
        logic [31:0] rd2;
        @(negedge clk);
        wb_xfer(32'h04, 32'd5, 4'hF, 1'b1, rd2);
      end
    join
    w = '{2, 2, 5, 5, 5, 5};
    for (int k = 0; k < 30; k++) exp_step[k] = 1'b0;
    pos = 0;
    for (int p = 0; p < 6; p++) begin
      for (int j = 0; j < w[p]; j++) begin
        exp_step[pos] = (p % 2 == 0);
        pos++;
      end
    end
    for (int k = 0; k < 30; k++) begin
      check($sformatf("pc_step_k%0d", k), 32'(got_step[k]), 32'(exp_step[k]));
      check($sformatf("pc_done_k%0d", k), 32'(got_done[k]), 32'(k == 24));
    end

    // irq on ch2 with IE, cleared by W1C
    wr(32'h24, 32'd1);
    check("irq_pre", 32'(irq), 0);
    wr(32'h28, 32'd1);
    wr(32'h20, 32'h9);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (done[2]) found = 1'b1;
    end
    check("irq_done_seen", 32'(found), 1);
    check("irq_set", 32'(irq), 1);
    rd_check("irq_status", 32'h2C, 32'h2);
    check("irq_held", 32'(irq), 1);
    wr(32'h2C, 32'h2);
    @(negedge clk);
    check("irq_clr", 32'(irq), 0);

    // Reset mid-move and mid-write
    wr(32'h04, 32'd3);
    wr(32'h08, 32'd5);
    wr(32'h00, 32'h3);
    repeat (4) @(negedge clk);
    check("r_busy_pre", 32'(busy[0]), 1);
    check("r_dir_pre", 32'(dir[0]), 1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h04; wdat = 32'h55; sel = 4'hF;
    @(posedge clk);
    #2;
    check("r_ack_pre", 32'(ack), 1);
    rst_n = 1'b0;
    #1;
    check("r_ack", 32'(ack), 0);
    check("r_dat", rdat, 0);
    check("r_step", 32'(step), 0);
    check("r_dir", 32'(dir), 0);
    check("r_busy", 32'(busy), 0);
    check("r_done", 32'(done), 0);
    check("r_irq", 32'(irq), 0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("r_no_done", 32'(done), 0);
    check("r_idle", 32'(busy), 0);
    rd_check("r_period", 32'h04, 32'h1);
    rd_check("r_steps", 32'h08, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
